// File: rtl/mac_accumulator_if.sv
// mac_accumulator_if
//  Bundles the product-stream input, bias, the valid/ready result port and the
//  status flags of mac_accumulator.
//  Modports:
//   master : drives in_valid/in_last/in_data/bias/out_ready, observes results
//   slave  : the accumulator side (consumes the stream, drives the results)
//  Signals:
//   in_valid, in_last, in_data[15:0]   product stream (no backpressure)
//   bias[ACC_W-1:0]                    sampled on the first beat of a vector
//   out_valid, out_ready               one-entry result handshake
//   out_data[OUT_W-1:0]                requantized result
//   out_acc[ACC_W-1:0]                 raw final sum
//   out_len[CNT_W-1:0]                 element count, saturating
//   busy, drop_err                     status
interface mac_accumulator_if #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 8,
    parameter int CNT_W = 10
);
    logic             in_valid;
    logic             in_last;
    logic [15:0]      in_data;
    logic [ACC_W-1:0] bias;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_len;
    logic             busy;
    logic             drop_err;

    modport master (
        output in_valid, in_last, in_data, bias, out_ready,
        input  out_valid, out_data, out_acc, out_len, busy, drop_err
    );

    modport slave (
        input  in_valid, in_last, in_data, bias, out_ready,
        output out_valid, out_data, out_acc, out_len, busy, drop_err
    );
endinterface

// File: rtl/mac_accumulator.sv
// mac_accumulator
//  Sums one vector of signed 16-bit products per neuron, starting from a bias
//  sampled on the first beat. The final sum is rounded, arithmetically shifted
//  by SHIFT, saturated to OUT_W bits and held in a one-entry valid/ready
//  output register.
//  Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset
//   bus      mac_accumulator_if.slave (stream in, result out, status)
//  Optional build macro:
//   ACC_RELU_EN  when defined, negative saturated results are forced to 0
//                (out_acc stays raw).
module mac_accumulator #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 8,
    parameter int SHIFT = 7,
    parameter int CNT_W = 10
) (
    input  logic            clk,
    input  logic            rst,
    mac_accumulator_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
    localparam logic [OUT_W-1:0] OUT_ZERO = {OUT_W{1'b0}};

    // Rounding constant: half an LSB of the shifted result, nothing when SHIFT=0.
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [ACC_W:0] RND = (SHIFT > 0)
        ? ({{ACC_W{1'b0}}, 1'b1} << RND_POS) : {(ACC_W+1){1'b0}};

    // Saturation limits sign-extended to the ACC_W+1 requant width.
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    state_t                  state_q;
    logic signed [ACC_W-1:0] acc_q;
    logic        [CNT_W-1:0] cnt_q;
    logic                    busy_q;
    logic                    out_valid_q;
    logic        [OUT_W-1:0] out_data_q;
    logic        [ACC_W-1:0] out_acc_q;
    logic        [CNT_W-1:0] out_len_q;
    logic                    drop_err_q;

    logic signed [ACC_W-1:0] data_ext_s;
    logic signed [ACC_W-1:0] base_s;
    logic signed [ACC_W-1:0] sum_d;
    logic        [CNT_W-1:0] len_d;
    logic signed [ACC_W:0]   wide_s;
    logic signed [ACC_W:0]   shifted_s;
    logic        [OUT_W-1:0] sat_s;
    logic        [OUT_W-1:0] data_d;
    logic                    complete_s;
    logic                    load_s;
    logic                    drop_s;

    // Running sum including this beat; a new vector starts from the bias.
    always_comb begin
        data_ext_s = {{(ACC_W-16){bus.in_data[15]}}, bus.in_data};
        base_s     = ACC_ZERO;
        if (state_q == ACCUM) begin
            base_s = acc_q;
        end else begin
            base_s = bus.bias;
        end
        sum_d = base_s + data_ext_s;
    end

    // Element count including this beat, saturating at all-ones.
    always_comb begin
        len_d = CNT_ONE;
        if (state_q == ACCUM) begin
            if (cnt_q == CNT_MAX) begin
                len_d = CNT_MAX;
            end else begin
                len_d = cnt_q + CNT_ONE;
            end
        end else begin
            len_d = CNT_ONE;
        end
    end

    // Round, shift and saturate the final sum (one extra bit so rounding cannot wrap).
    always_comb begin
        wide_s    = {sum_d[ACC_W-1], sum_d} + RND;
        shifted_s = wide_s >>> SHIFT;
        sat_s     = shifted_s[OUT_W-1:0];
        if (shifted_s > SAT_MAX) begin
            sat_s = SAT_MAX[OUT_W-1:0];
        end else if (shifted_s < SAT_MIN) begin
            sat_s = SAT_MIN[OUT_W-1:0];
        end else begin
            sat_s = shifted_s[OUT_W-1:0];
        end
    end

    // Optional ReLU clamp on the saturated result.
    always_comb begin
        data_d = sat_s;
`ifdef ACC_RELU_EN
        if (sat_s[OUT_W-1]) begin
            data_d = OUT_ZERO;
        end else begin
            data_d = sat_s;
        end
`else
        data_d = sat_s;
`endif
    end

    // A completion loads the output register only if it is empty or draining now.
    always_comb begin
        complete_s = bus.in_valid & bus.in_last;
        load_s     = complete_s & (~out_valid_q | bus.out_ready);
        drop_s     = complete_s & out_valid_q & ~bus.out_ready;
    end

    // Accumulator FSM plus output register and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= ACC_ZERO;
            cnt_q       <= CNT_ZERO;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= OUT_ZERO;
            out_acc_q   <= ACC_ZERO;
            out_len_q   <= CNT_ZERO;
            drop_err_q  <= 1'b0;
        end else begin
            if (bus.in_valid) begin
                if (bus.in_last) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    acc_q   <= ACC_ZERO;
                    cnt_q   <= CNT_ZERO;
                end else begin
                    state_q <= ACCUM;
                    busy_q  <= 1'b1;
                    acc_q   <= sum_d;
                    cnt_q   <= len_d;
                end
            end else begin
                state_q <= state_q;
                busy_q  <= busy_q;
            end

            if (load_s) begin
                out_valid_q <= 1'b1;
                out_data_q  <= data_d;
                out_acc_q   <= sum_d;
                out_len_q   <= len_d;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end else begin
                out_valid_q <= out_valid_q;
            end

            if (drop_s) begin
                drop_err_q <= 1'b1;
            end else begin
                drop_err_q <= drop_err_q;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_acc   = out_acc_q;
    assign bus.out_len   = out_len_q;
    assign bus.busy      = busy_q;
    assign bus.drop_err  = drop_err_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator
//  Directed bench: two accumulators (SHIFT=0 and SHIFT=7) share one stimulus
//  stream; expectations are hand-computed constants.
module tb_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_last;
    logic [15:0] in_data;
    logic [31:0] bias;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    mac_accumulator_if #(.ACC_W(32), .OUT_W(8), .CNT_W(10)) b0 ();
    mac_accumulator_if #(.ACC_W(32), .OUT_W(8), .CNT_W(10)) b7 ();

    assign b0.in_valid  = in_valid;
    assign b0.in_last   = in_last;
    assign b0.in_data   = in_data;
    assign b0.bias      = bias;
    assign b0.out_ready = out_ready;
    assign b7.in_valid  = in_valid;
    assign b7.in_last   = in_last;
    assign b7.in_data   = in_data;
    assign b7.bias      = bias;
    assign b7.out_ready = out_ready;

    mac_accumulator #(.ACC_W(32), .OUT_W(8), .SHIFT(0), .CNT_W(10)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    mac_accumulator #(.ACC_W(32), .OUT_W(8), .SHIFT(7), .CNT_W(10)) u_dut7 (
        .clk (clk),
        .rst (rst),
        .bus (b7.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 16'h0000;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, b0.out_valid}, 32'd0);
        chk({tag, "_data"},  {24'd0, b0.out_data},  32'd0);
        chk({tag, "_acc"},   b0.out_acc,            32'd0);
        chk({tag, "_len"},   {22'd0, b0.out_len},   32'd0);
        chk({tag, "_busy"},  {31'd0, b0.busy},      32'd0);
        chk({tag, "_drop"},  {31'd0, b0.drop_err},  32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 16'h0000;
        bias      = 32'd0;
        out_ready = 1'b0;

        // 1. reset for two cycles, then idle
        step();
        step();
        chk_zero("rst");
        rst = 1'b0;
        step();
        chk_zero("idle");

        // 2. bias 10, beats +5 +7 -2(last)
        out_ready = 1'b1;
        bias      = 32'd10;
        beat(16'd5, 1'b0);
        chk("t2_busy", {31'd0, b0.busy}, 32'd1);
        chk("t2_novalid", {31'd0, b0.out_valid}, 32'd0);
        beat(16'd7, 1'b0);
        beat(16'hFFFE, 1'b1);
        chk("t2_valid", {31'd0, b0.out_valid}, 32'd1);
        chk("t2_acc", b0.out_acc, 32'd20);
        chk("t2_data", {24'd0, b0.out_data}, 32'd20);
        chk("t2_len", {22'd0, b0.out_len}, 32'd3);
        chk("t2_busy_off", {31'd0, b0.busy}, 32'd0);
        chk("t2_data_s7", {24'd0, b7.out_data}, 32'd0);
        step();
        chk("t2_drain", {31'd0, b0.out_valid}, 32'd0);

        // 3. single beat -300, bias 0
        bias = 32'd0;
        beat(16'hFED4, 1'b1);
        chk("t3_acc", b0.out_acc, 32'hFFFFFED4);
        chk("t3_len", {22'd0, b0.out_len}, 32'd1);
`ifdef ACC_RELU_EN
        chk("t3_data", {24'd0, b0.out_data}, 32'h00);
        chk("t3_data_s7", {24'd0, b7.out_data}, 32'h00);
`else
        chk("t3_data", {24'd0, b0.out_data}, 32'h80);
        chk("t3_data_s7", {24'd0, b7.out_data}, 32'hFE);
`endif
        step();

        // 4. four beats of 255*127 -> 129540, saturates to 127
        beat(16'd32385, 1'b0);
        beat(16'd32385, 1'b0);
        beat(16'd32385, 1'b0);
        beat(16'd32385, 1'b1);
        chk("t4_acc", b7.out_acc, 32'd129540);
        chk("t4_data_s7", {24'd0, b7.out_data}, 32'h7F);
        chk("t4_data_s0", {24'd0, b0.out_data}, 32'h7F);
        chk("t4_len", {22'd0, b7.out_len}, 32'd4);
        // sum 192 rounds to 2 with SHIFT=7
        beat(16'd100, 1'b0);
        beat(16'd92, 1'b1);
        chk("t4_acc192", b7.out_acc, 32'd192);
        chk("t4_data192_s7", {24'd0, b7.out_data}, 32'h02);
        chk("t4_data192_s0", {24'd0, b0.out_data}, 32'h7F);
        step();

        // 5. backpressure: first held, second dropped, then coincident load
        out_ready = 1'b0;
        beat(16'd1, 1'b1);
        chk("t5_held_valid", {31'd0, b0.out_valid}, 32'd1);
        chk("t5_held_acc", b0.out_acc, 32'd1);
        chk("t5_no_drop", {31'd0, b0.drop_err}, 32'd0);
        beat(16'd2, 1'b1);
        chk("t5_kept_acc", b0.out_acc, 32'd1);
        chk("t5_drop", {31'd0, b0.drop_err}, 32'd1);
        chk("t5_kept_valid", {31'd0, b0.out_valid}, 32'd1);
        step();
        chk("t5_stable_acc", b0.out_acc, 32'd1);
        out_ready = 1'b1;
        beat(16'd3, 1'b1);
        chk("t5_coinc_valid", {31'd0, b0.out_valid}, 32'd1);
        chk("t5_coinc_acc", b0.out_acc, 32'd3);
        chk("t5_drop_sticky", {31'd0, b0.drop_err}, 32'd1);
        step();
        chk("t5_drain", {31'd0, b0.out_valid}, 32'd0);

        // 6. reset mid-vector, then a fresh two-beat vector
        bias = 32'd1000;
        beat(16'd1, 1'b0);
        beat(16'd2, 1'b0);
        beat(16'd3, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_busy", {31'd0, b0.busy}, 32'd0);
        chk("t6_rst_drop", {31'd0, b0.drop_err}, 32'd0);
        bias = 32'd50;
        beat(16'd4, 1'b0);
        beat(16'd6, 1'b1);
        chk("t6_acc", b0.out_acc, 32'd60);
        chk("t6_len", {22'd0, b0.out_len}, 32'd2);
        chk("t6_data", {24'd0, b0.out_data}, 32'd60);
        chk("t6_data_s7", {24'd0, b7.out_data}, 32'd0);
        step();

        // 7. element counter saturates at 1023
        bias = 32'd0;
        for (int i = 0; i < 1029; i++) begin
            beat(16'd0, 1'b0);
        end
        beat(16'd1, 1'b1);
        chk("t7_len_sat", {22'd0, b0.out_len}, 32'd1023);
        chk("t7_acc", b0.out_acc, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
